// File: rtl/cam_key_manager.sv
// Request front-end for the shift-register CAM: serialises insert/delete, detects duplicates and
// missing keys, allocates the lowest free entry, drives the CAM write port and returns status/address.
module cam_key_manager #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req_key,
    input  logic                  req_delete,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [1:0]            resp_status,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH:0]   used_count,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(N);

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_DUPLICATE = 2'd1;
    localparam logic [1:0] ST_NOT_FOUND = 2'd2;
    localparam logic [1:0] ST_FULL      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DECIDE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] key_reg;
    logic                  op_reg;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [N-1:0]          valid_bits;
    logic [ADDR_WIDTH-1:0] free_addr;
    logic                  decide_resp;

    assign cam_compare_data = key_reg;
    assign full             = (used_count == FULL_COUNT);

    // Lowest clear occupancy bit wins; the downward scan leaves the smallest index.
    always_comb begin
        free_addr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                free_addr = i[ADDR_WIDTH-1:0];
            end
        end
    end

    // Answer straight away for duplicate insert, missing delete, or insert into a full table.
    assign decide_resp = (!op_reg && cam_match) || (op_reg && !cam_match) || (!op_reg && full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        cam_write_enable = 1'b0;
        cam_write_addr   = '0;
        cam_write_data   = '0;
        cam_write_delete = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: state_next = S_DECIDE;
            S_DECIDE: state_next = decide_resp ? S_RESP : S_ISSUE;
            S_ISSUE: begin
                if (!cam_write_busy) begin
                    cam_write_enable = 1'b1;
                    cam_write_addr   = wr_addr;
                    cam_write_data   = key_reg;
                    cam_write_delete = op_reg;
                    state_next       = S_WAIT;
                end
            end
            // The cycle that sees busy low doubles as the settle cycle for the CAM match register.
            S_WAIT: begin
                if (!cam_write_busy) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg     <= '0;
            op_reg      <= 1'b0;
            wr_addr     <= '0;
            resp_status <= ST_OK;
            resp_addr   <= '0;
            valid_bits  <= '0;
            used_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        key_reg <= req_key;
                        op_reg  <= req_delete;
                    end
                end
                S_DECIDE: begin
                    if (cam_match) begin
                        if (!op_reg) begin
                            resp_status <= ST_DUPLICATE;
                            resp_addr   <= cam_match_addr;
                        end else begin
                            wr_addr <= cam_match_addr;
                        end
                    end else if (op_reg) begin
                        resp_status <= ST_NOT_FOUND;
                        resp_addr   <= '0;
                    end else if (full) begin
                        resp_status <= ST_FULL;
                        resp_addr   <= '0;
                    end else begin
                        wr_addr <= free_addr;
                    end
                end
                S_ISSUE: begin
                    if (!cam_write_busy) begin
                        valid_bits[wr_addr] <= !op_reg;
                        // Count only real occupancy transitions so the counter cannot drift.
                        if (valid_bits[wr_addr] == op_reg) begin
                            used_count <= op_reg ? used_count - 1'b1 : used_count + 1'b1;
                        end
                        resp_status <= ST_OK;
                        resp_addr   <= wr_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_key_manager.sv
// Bench for cam_key_manager: behavioural CAM, reference occupancy model and response scoreboard.
module tb_cam_key_manager;

    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int N    = 1 << AW;
    localparam int BUSY = 16;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_DUPLICATE = 2'd1;
    localparam logic [1:0] ST_NOT_FOUND = 2'd2;
    localparam logic [1:0] ST_FULL      = 2'd3;

    typedef struct {
        logic [1:0]    status;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] req_key = '0;
    logic          req_delete = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    resp_status;
    logic [AW-1:0] resp_addr;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [AW:0]   used_count;
    logic          full;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;

    always #5 clk = ~clk;

    cam_key_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_key          (req_key),
        .req_delete       (req_delete),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .resp_status      (resp_status),
        .resp_addr        (resp_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .used_count       (used_count),
        .full             (full),
        .cam_write_addr   (cam_write_addr),
        .cam_write_data   (cam_write_data),
        .cam_write_delete (cam_write_delete),
        .cam_write_enable (cam_write_enable),
        .cam_write_busy   (cam_write_busy),
        .cam_compare_data (cam_compare_data),
        .cam_match        (cam_match),
        .cam_match_addr   (cam_match_addr)
    );

    // Behavioural CAM: init busy after reset, busy after every write, registered match.
    logic [DW-1:0] cam_mem [N];
    logic [N-1:0]  cam_vld;
    int            busy_cnt;

    assign cam_write_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            cam_vld        <= '0;
            busy_cnt       <= BUSY;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
        end else begin
            if (cam_write_enable) begin
                cam_mem[cam_write_addr] <= cam_write_data;
                cam_vld[cam_write_addr] <= !cam_write_delete;
                busy_cnt                <= BUSY;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (cam_vld[i] && cam_mem[i] == cam_compare_data) begin
                    cam_match      <= 1'b1;
                    cam_match_addr <= AW'(i);
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference occupancy model
    logic          ref_vld [N];
    logic [DW-1:0] ref_key [N];

    function automatic int ref_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += ref_vld[i] ? 1 : 0;
        return c;
    endfunction

    function automatic exp_t predict(input logic [DW-1:0] key, input logic del);
        exp_t e;
        int   hit = -1;
        int   fr  = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (ref_vld[i] && ref_key[i] == key) hit = i;
            if (!ref_vld[i]) fr = i;
        end
        e.addr = '0;
        if (!del) begin
            if (hit >= 0) begin
                e.status = ST_DUPLICATE;
                e.addr   = AW'(hit);
            end else if (fr < 0) begin
                e.status = ST_FULL;
            end else begin
                e.status    = ST_OK;
                e.addr      = AW'(fr);
                ref_vld[fr] = 1'b1;
                ref_key[fr] = key;
            end
        end else if (hit >= 0) begin
            e.status     = ST_OK;
            e.addr       = AW'(hit);
            ref_vld[hit] = 1'b0;
        end else begin
            e.status = ST_NOT_FOUND;
        end
        return e;
    endfunction

    exp_t          exp_q[$];
    int            cyc = 0;
    int            wr_pulses = 0;
    int            resp_cnt = 0;
    int            first_valid_cyc = -1;
    int            idle_leaks = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    logic          last_wr_del;

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor: write-port capture and scoreboard pop on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cam_write_enable) begin
                wr_pulses++;
                last_wr_addr = cam_write_addr;
                last_wr_data = cam_write_data;
                last_wr_del  = cam_write_delete;
            end else if (cam_write_addr != '0 || cam_write_data != '0 || cam_write_delete) begin
                idle_leaks++;
            end
            if (resp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_status", 64'(resp_status), 64'(e.status));
                    check("resp_addr", 64'(resp_addr), 64'(e.addr));
                end
                resp_cnt++;
            end
        end
    end

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < N; i++) ref_vld[i] = 1'b0;
        rst = 1'b0;
    endtask

    // Drives one request; returns with req_valid low. exp_lat < 0 skips the latency check.
    task automatic send(input logic [DW-1:0] key, input logic del, input int exp_lat, input int hold);
        exp_t e;
        int   p0, r0, acc;
        bit   ok;
        first_valid_cyc = -1;
        e  = predict(key, del);
        exp_q.push_back(e);
        p0 = wr_pulses;
        r0 = resp_cnt;
        acc = 0;
        req_key    = key;
        req_delete = del;
        req_valid  = 1'b1;
        if (hold > 0) resp_ready = 1'b0;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok  = 1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            resp_ready = 1'b1;
            return;
        end
        if (hold > 0) begin
            for (int k = 0; k < 300 && !resp_valid; k++) @(negedge clk);
            check("hold_valid_seen", 64'(resp_valid), 64'd1);
            req_key   = ~key;
            req_valid = 1'b1;
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                check("hold_resp_valid", 64'(resp_valid), 64'd1);
                check("hold_status", 64'(resp_status), 64'(e.status));
                check("hold_addr", 64'(resp_addr), 64'(e.addr));
                check("hold_req_ready", 64'(req_ready), 64'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        for (int k = 0; k < 300 && resp_cnt == r0; k++) begin
            @(posedge clk);
            #1;
        end
        check("resp_seen", 64'(resp_cnt - r0), 64'd1);
        if (exp_lat >= 0) check("latency", 64'(first_valid_cyc - acc), 64'(exp_lat));
        check("used_count", 64'(used_count), 64'(ref_count()));
        check("full", 64'(full), 64'(ref_count() == N));
        check("wr_pulses", 64'(wr_pulses - p0), (e.status == ST_OK) ? 64'd1 : 64'd0);
        if (e.status == ST_OK) begin
            check("wr_delete", 64'(last_wr_del), 64'(del));
            check("wr_addr", 64'(last_wr_addr), 64'(e.addr));
            check("wr_data", last_wr_data, key);
        end
    endtask

    initial begin
        int p0, r0;
        bit ok;
        for (int i = 0; i < N; i++) ref_vld[i] = 1'b0;

        // Reset state, sampled while reset is still held
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_status", 64'(resp_status), 64'd0);
        check("rst_resp_addr", 64'(resp_addr), 64'd0);
        check("rst_used_count", 64'(used_count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_wr_enable", 64'(cam_write_enable), 64'd0);
        check("rst_compare_data", cam_compare_data, 64'd0);
        rst = 1'b0;

        // 1: insert straight after reset, stalls behind CAM init
        send(64'hAB, 1'b0, -1, 0);
        // 2: duplicate
        send(64'hAB, 1'b0, 3, 0);
        // 3: delete missing, then delete present
        send(64'h55, 1'b1, 3, 0);
        send(64'hAB, 1'b1, 5 + BUSY, 0);
        // 4: fill the table, overflow, free a slot and reuse it
        for (int i = 0; i < N; i++) send(64'(i), 1'b0, 5 + BUSY, 0);
        check("filled_full", 64'(full), 64'd1);
        send(64'd99, 1'b0, 3, 0);
        send(64'd5, 1'b1, 5 + BUSY, 0);
        send(64'd99, 1'b0, 5 + BUSY, 0);
        check("reuse_addr5", 64'(last_wr_addr), 64'd5);
        // 5: response back-pressure
        send(64'd0, 1'b1, 5 + BUSY, 0);
        send(64'h77, 1'b0, 5 + BUSY, 10);
        send(64'd1, 1'b1, 5 + BUSY, 0);

        // 6: reset while waiting for the CAM to finish a write
        p0 = wr_pulses;
        r0 = resp_cnt;
        req_key    = 64'h33;
        req_delete = 1'b0;
        req_valid  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (wr_pulses != p0) ok = 1;
        end
        check("wait_write_seen", 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        do_reset(2);
        @(negedge clk);
        check("post_rst_used_count", 64'(used_count), 64'd0);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_full", 64'(full), 64'd0);
        repeat (10) @(negedge clk);
        check("post_rst_no_resp", 64'(resp_cnt - r0), 64'd0);
        send(64'h44, 1'b0, -1, 0);
        check("post_rst_alloc", 64'(last_wr_addr), 64'd0);

        check("wr_idle_zero", 64'(idle_leaks), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
